// File: rtl/ising_energy_scanner_pkg.sv
// ---------------------------------------------------------------------------
// spectrum_pkg
// Shared types and helpers for the Ising energy scanner.
//   scan_state_t : scanner FSM states (IDLE, HSCAN, VSCAN, DONE)
//   spin_prod()  : product of the spins of two image words (+1 or -1)
// ---------------------------------------------------------------------------
package spectrum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HSCAN = 2'd1,
    VSCAN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Only bit 31 carries the spin (0 -> +1, 1 -> -1), so equal sign bits
  // give +1 and differing sign bits give -1.
  function automatic logic signed [31:0] spin_prod(input logic [31:0] word_a,
                                                   input logic [31:0] word_b);
    logic signed [31:0] prod;
    if (word_a[31] == word_b[31]) begin
      prod = 32'sd1;
    end else begin
      prod = -32'sd1;
    end
    return prod;
  endfunction

endpackage

// File: rtl/ising_energy_scanner_if.sv
// ---------------------------------------------------------------------------
// ising_energy_scanner_if
// Bundle of the scanner's request, memory read and result signals.
//   master : requester / memory side (drives start and read data)
//   slave  : scanner side (drives addresses, status and results)
// ---------------------------------------------------------------------------
interface ising_energy_scanner_if;

  logic               start;
  logic        [31:0] rd_data1;
  logic        [31:0] rd_data2;
  logic        [31:0] rd_addr1;
  logic        [31:0] rd_addr2;
  logic               busy;
  logic               done;
  logic signed [31:0] energy;
  logic        [31:0] cut_count;

  modport master (
    output start, rd_data1, rd_data2,
    input  rd_addr1, rd_addr2, busy, done, energy, cut_count
  );

  modport slave (
    input  start, rd_data1, rd_data2,
    output rd_addr1, rd_addr2, busy, done, energy, cut_count
  );

endinterface

// File: rtl/ising_energy_scanner_walker.sv
// ---------------------------------------------------------------------------
// ising_pair_walker
// Row/column counters for the neighbour-pair walk, last-pair detection and
// combinational address decode for both memory read ports.
//   clk, rst  : clock, asynchronous active-low reset
//   state     : current scanner FSM state
//   last_pair : current pair is the final one of the active scan phase
//   rd_addr1  : address of the pair's first pixel (0 outside scan phases)
//   rd_addr2  : address of the neighbour pixel   (0 outside scan phases)
// ---------------------------------------------------------------------------
module ising_pair_walker
  import spectrum_pkg::*;
#(
  parameter int IMG_ROWS = 4,
  parameter int IMG_COLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  scan_state_t state,
  output logic        last_pair,
  output logic [31:0] rd_addr1,
  output logic [31:0] rd_addr2
);

  localparam logic [31:0] COLS       = 32'(IMG_COLS);
  localparam logic [31:0] LAST_COL   = 32'(IMG_COLS - 1);
  localparam logic [31:0] LAST_ROW   = 32'(IMG_ROWS - 1);
  // Horizontal pairs stop one column early, vertical pairs one row early.
  // Clamped so degenerate sizes never produce a negative constant; those
  // phases are skipped by the FSM anyway.
  localparam logic [31:0] H_LAST_COL = (IMG_COLS >= 2) ? 32'(IMG_COLS - 2) : 32'd0;
  localparam logic [31:0] V_LAST_ROW = (IMG_ROWS >= 2) ? 32'(IMG_ROWS - 2) : 32'd0;

  logic [31:0] row;
  logic [31:0] col;
  logic [31:0] base;
  logic        h_wrap;
  logic        v_wrap;
  logic        h_last;
  logic        v_last;

  // Wrap and last-pair detection for both scan phases.
  always_comb begin
    base   = row * COLS + col;
    h_wrap = (col == H_LAST_COL);
    v_wrap = (col == LAST_COL);
    h_last = h_wrap && (row == LAST_ROW);
    v_last = v_wrap && (row == V_LAST_ROW);
  end

  // Address decode: right neighbour in HSCAN, lower neighbour in VSCAN.
  always_comb begin
    last_pair = 1'b0;
    rd_addr1  = 32'd0;
    rd_addr2  = 32'd0;
    case (state)
      HSCAN: begin
        last_pair = h_last;
        rd_addr1  = base;
        rd_addr2  = base + 32'd1;
      end
      VSCAN: begin
        last_pair = v_last;
        rd_addr1  = base;
        rd_addr2  = base + COLS;
      end
      default: begin
        last_pair = 1'b0;
        rd_addr1  = 32'd0;
        rd_addr2  = 32'd0;
      end
    endcase
  end

  // Counters advance once per scan cycle and return to 0 at the end of
  // each phase so the next phase starts from pixel (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= 32'd0;
      col <= 32'd0;
    end else begin
      case (state)
        HSCAN: begin
          if (h_last) begin
            row <= 32'd0;
            col <= 32'd0;
          end else if (h_wrap) begin
            row <= row + 32'd1;
            col <= 32'd0;
          end else begin
            col <= col + 32'd1;
          end
        end
        VSCAN: begin
          if (v_last) begin
            row <= 32'd0;
            col <= 32'd0;
          end else if (v_wrap) begin
            row <= row + 32'd1;
            col <= 32'd0;
          end else begin
            col <= col + 32'd1;
          end
        end
        default: begin
          row <= 32'd0;
          col <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ising_energy_scanner.sv
// ---------------------------------------------------------------------------
// ising_energy_scanner
// Walks every horizontal and vertical neighbour pair of the image (one pair
// per clock via two zero-latency read ports) and publishes the Ising energy
// (-sum of spin products) and the cut size (number of disagreeing pairs).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : start request, read ports, busy/done status and results
// ---------------------------------------------------------------------------
module ising_energy_scanner
  import spectrum_pkg::*;
#(
  parameter int IMG_ROWS = 4,
  parameter int IMG_COLS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  ising_energy_scanner_if.slave        bus
);

  localparam int NPAIRS = IMG_ROWS * (IMG_COLS - 1) + (IMG_ROWS - 1) * IMG_COLS;

  scan_state_t        state;
  logic signed [31:0] sum;
  logic        [31:0] cut;
  logic signed [31:0] prod;
  logic               mismatch;
  logic signed [31:0] sum_next;
  logic        [31:0] cut_next;
  logic               last_pair;
  logic        [31:0] addr1;
  logic        [31:0] addr2;
  logic               busy;
  logic               done;
  logic signed [31:0] energy;
  logic        [31:0] cut_count;

  ising_pair_walker #(
    .IMG_ROWS (IMG_ROWS),
    .IMG_COLS (IMG_COLS)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .last_pair (last_pair),
    .rd_addr1  (addr1),
    .rd_addr2  (addr2)
  );

  assign bus.rd_addr1  = addr1;
  assign bus.rd_addr2  = addr2;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.energy    = energy;
  assign bus.cut_count = cut_count;

  // Running totals including the pair presented this cycle.
  always_comb begin
    prod     = spin_prod(bus.rd_data1, bus.rd_data2);
    mismatch = prod[31];
    sum_next = sum + prod;
    cut_next = cut + {31'd0, mismatch};
  end

  // Scan FSM with accumulators and registered status/result outputs.
  // Results are captured on the edge that enters DONE; done itself pulses
  // on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sum       <= 32'sd0;
      cut       <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      energy    <= 32'sd0;
      cut_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          sum  <= 32'sd0;
          cut  <= 32'd0;
          done <= 1'b0;
          if (bus.start) begin
            busy <= 1'b1;
            if (NPAIRS == 0) begin
              state     <= DONE;
              energy    <= 32'sd0;
              cut_count <= 32'd0;
            end else if (IMG_COLS == 1) begin
              state <= VSCAN;
            end else begin
              state <= HSCAN;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HSCAN: begin
          sum  <= sum_next;
          cut  <= cut_next;
          busy <= 1'b1;
          done <= 1'b0;
          if (last_pair) begin
            if (IMG_ROWS == 1) begin
              state     <= DONE;
              energy    <= -sum_next;
              cut_count <= cut_next;
            end else begin
              state <= VSCAN;
            end
          end else begin
            state <= HSCAN;
          end
        end
        VSCAN: begin
          sum  <= sum_next;
          cut  <= cut_next;
          busy <= 1'b1;
          done <= 1'b0;
          if (last_pair) begin
            state     <= DONE;
            energy    <= -sum_next;
            cut_count <= cut_next;
          end else begin
            state <= VSCAN;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ising_energy_scanner.sv
// ---------------------------------------------------------------------------
// tb_ising_energy_scanner
// Directed bench for a 4x4 and a 1x4 scanner, each backed by a small
// combinational word memory.
// ---------------------------------------------------------------------------
module tb_ising_energy_scanner;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem4 [16];
  logic [31:0] mem1 [4];

  ising_energy_scanner_if b4 ();
  ising_energy_scanner_if b1 ();

  ising_energy_scanner #(.IMG_ROWS(4), .IMG_COLS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  ising_energy_scanner #(.IMG_ROWS(1), .IMG_COLS(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  assign b4.rd_data1 = (b4.rd_addr1 < 32'd16) ? mem4[b4.rd_addr1[3:0]] : 32'hDEAD_BEEF;
  assign b4.rd_data2 = (b4.rd_addr2 < 32'd16) ? mem4[b4.rd_addr2[3:0]] : 32'hDEAD_BEEF;
  assign b1.rd_data1 = (b1.rd_addr1 < 32'd4)  ? mem1[b1.rd_addr1[1:0]] : 32'hDEAD_BEEF;
  assign b1.rd_data2 = (b1.rd_addr2 < 32'd4)  ? mem1[b1.rd_addr2[1:0]] : 32'hDEAD_BEEF;

  // Pulse start on one DUT and time done/busy relative to the sampling edge.
  // done_at = number of edges after the start edge at which done is seen.
  task automatic do_scan(input bit sel, input int npairs,
                         output int done_at, output int busy_err);
    logic busy_now;
    @(negedge clk);
    if (sel) b1.start = 1'b1; else b4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.start = 1'b0;
    b4.start = 1'b0;
    done_at  = -1;
    busy_err = 0;
    for (int j = 0; j < npairs + 10 && done_at < 0; j++) begin
      if (j > 0) @(negedge clk);
      busy_now = sel ? b1.busy : b4.busy;
      if ((sel ? b1.done : b4.done) === 1'b1) done_at = j;
      if (busy_now !== (j <= npairs)) busy_err++;
    end
  endtask

  task automatic fill_checker();
    for (int i = 0; i < 16; i++) mem4[i] = (((i / 4) + (i % 4)) % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b4.start = 1'b0;
    b1.start = 1'b0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) mem1[i] = 32'h0000_5A5A;
    repeat (3) @(negedge clk);
    checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b4.busy); end
    checks++; if (b4.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", b4.done); end
    checks++; if (b4.energy !== 32'sd0) begin errors++; $display("FAIL reset_energy: got %0d expected 0", b4.energy); end
    checks++; if (b4.cut_count !== 32'd0) begin errors++; $display("FAIL reset_cut: got %0d expected 0", b4.cut_count); end
    checks++; if (b4.rd_addr1 !== 32'd0 || b4.rd_addr2 !== 32'd0) begin
      errors++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", b4.rd_addr1, b4.rd_addr2);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_minus();
    int d, be;
    do_scan(1'b0, 24, d, be);
    checks++; if (d != 25) begin errors++; $display("FAIL allm_done_time: got %0d expected 25", d); end
    checks++; if (be != 0) begin errors++; $display("FAIL allm_busy: got %0d bad cycles expected 0", be); end
    checks++; if (b4.energy !== -32'sd24) begin errors++; $display("FAIL allm_energy: got %0d expected -24", b4.energy); end
    checks++; if (b4.cut_count !== 32'd0) begin errors++; $display("FAIL allm_cut: got %0d expected 0", b4.cut_count); end
    checks++; if (b4.rd_addr1 !== 32'd0 || b4.rd_addr2 !== 32'd0) begin
      errors++; $display("FAIL idle_addr: got %0d/%0d expected 0/0", b4.rd_addr1, b4.rd_addr2);
    end
  endtask

  task automatic test_checkerboard();
    int d, be;
    fill_checker();
    do_scan(1'b0, 24, d, be);
    checks++; if (d != 25) begin errors++; $display("FAIL chk_done_time: got %0d expected 25", d); end
    checks++; if (b4.energy !== 32'sd24) begin errors++; $display("FAIL chk_energy: got %0d expected 24", b4.energy); end
    checks++; if (b4.cut_count !== 32'd24) begin errors++; $display("FAIL chk_cut: got %0d expected 24", b4.cut_count); end
  endtask

  task automatic test_centre_block();
    logic [31:0] ea1, ea2;
    int d;
    // Low bits carry noise: only bit 31 may influence the spin.
    for (int i = 0; i < 16; i++) begin
      if ((i / 4 == 1 || i / 4 == 2) && (i % 4 == 1 || i % 4 == 2)) mem4[i] = 32'h7FFF_1234;
      else mem4[i] = 32'h8000_00AB;
    end
    @(negedge clk);
    b4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.start = 1'b0;
    d = -1;
    for (int j = 0; j < 40 && d < 0; j++) begin
      if (j > 0) @(negedge clk);
      if (b4.done === 1'b1) d = j;
      if (j < 24) begin
        if (j < 12) ea1 = 32'((j / 3) * 4 + (j % 3));
        else        ea1 = 32'(j - 12);
        ea2 = (j < 12) ? ea1 + 32'd1 : ea1 + 32'd4;
        checks++;
        if (b4.rd_addr1 !== ea1 || b4.rd_addr2 !== ea2) begin
          errors++;
          $display("FAIL ctr_addr[%0d]: got %0d/%0d expected %0d/%0d", j, b4.rd_addr1, b4.rd_addr2, ea1, ea2);
        end
      end
    end
    checks++; if (d != 25) begin errors++; $display("FAIL ctr_done_time: got %0d expected 25", d); end
    checks++; if (b4.energy !== -32'sd8) begin errors++; $display("FAIL ctr_energy: got %0d expected -8", b4.energy); end
    checks++; if (b4.cut_count !== 32'd8) begin errors++; $display("FAIL ctr_cut: got %0d expected 8", b4.cut_count); end
  endtask

  task automatic test_start_held();
    int pos[$];
    @(negedge clk);
    b4.start = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      @(negedge clk);
      if (e == 30) b4.start = 1'b0;
      if (b4.done === 1'b1) pos.push_back(e);
    end
    checks++;
    if (pos.size() != 2) begin
      errors++; $display("FAIL held_done_count: got %0d expected 2", pos.size());
    end else begin
      checks++; if (pos[0] != 26) begin errors++; $display("FAIL held_done1: got %0d expected 26", pos[0]); end
      checks++; if (pos[1] != 52) begin errors++; $display("FAIL held_done2: got %0d expected 52", pos[1]); end
    end
    checks++; if (b4.energy !== -32'sd8) begin errors++; $display("FAIL held_energy: got %0d expected -8", b4.energy); end
  endtask

  task automatic test_mid_reset();
    int d, be;
    @(negedge clk);
    b4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (b4.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b expected 1", b4.busy); end
    rst = 1'b0;
    #1;
    checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      errors++; $display("FAIL mid_status: got busy=%b done=%b expected 0/0", b4.busy, b4.done);
    end
    checks++; if (b4.energy !== 32'sd0 || b4.cut_count !== 32'd0) begin
      errors++; $display("FAIL mid_results: got %0d/%0d expected 0/0", b4.energy, b4.cut_count);
    end
    checks++; if (b4.rd_addr1 !== 32'd0 || b4.rd_addr2 !== 32'd0) begin
      errors++; $display("FAIL mid_addr: got %0d/%0d expected 0/0", b4.rd_addr1, b4.rd_addr2);
    end
    @(negedge clk);
    rst = 1'b1;
    fill_checker();
    do_scan(1'b0, 24, d, be);
    checks++; if (d != 25) begin errors++; $display("FAIL post_rst_done_time: got %0d expected 25", d); end
    checks++; if (be != 0) begin errors++; $display("FAIL post_rst_busy: got %0d bad cycles expected 0", be); end
    checks++; if (b4.energy !== 32'sd24 || b4.cut_count !== 32'd24) begin
      errors++; $display("FAIL post_rst_results: got %0d/%0d expected 24/24", b4.energy, b4.cut_count);
    end
  endtask

  task automatic test_row_image();
    int d, be;
    do_scan(1'b1, 3, d, be);
    checks++; if (d != 4) begin errors++; $display("FAIL row_done_time: got %0d expected 4", d); end
    checks++; if (be != 0) begin errors++; $display("FAIL row_busy: got %0d bad cycles expected 0", be); end
    checks++; if (b1.energy !== -32'sd3) begin errors++; $display("FAIL row_energy: got %0d expected -3", b1.energy); end
    checks++; if (b1.cut_count !== 32'd0) begin errors++; $display("FAIL row_cut: got %0d expected 0", b1.cut_count); end
  endtask

  initial begin
    test_reset();
    test_all_minus();
    test_checkerboard();
    test_centre_block();
    test_start_held();
    test_mid_reset();
    test_row_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
